gate_demo_ctrl: RTL and testbench



---
 rtl/gate_demo_if.sv | 9 +
 rtl/gate_demo_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_gate_demo_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_demo_if.sv
// Board-side signal bundle for the two-button gate demo: raw buttons in, active-low LEDs out.
interface gate_demo_if;
    logic       btn1;
    logic       btn2;
    logic [5:0] led;

    modport master (output btn1, output btn2, input led);
    modport slave  (input btn1, input btn2, output led);
endinterface

// File: rtl/gate_demo_ctrl.sv
// Two-button logic-gate demo controller: debounce, chord-selected gate mode,
// automatic truth-table sweep and registered active-low LED drive.
module gate_demo_ctrl #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int STEP_CYCLES     = 13500000
) (
    input  logic        clk,
    input  logic        rst_n,
    gate_demo_if.slave  bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LG_W = $clog2(LONG_CYCLES + 1);
    localparam int ST_W = $clog2(STEP_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LG_W-1:0] LG_MAX = LG_W'(LONG_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STEP_CYCLES - 1);

    typedef enum logic {LIVE = 1'b0, SWEEP = 1'b1} top_state_e;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_HOLD = 2'd1, C_WAIT_REL = 2'd2} chord_state_e;

    function automatic logic gate_fn(input logic [2:0] mode, input logic a, input logic b);
        logic y;
        case (mode)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~(a ^ b);
            3'd4:    y = ~(a & b);
            3'd5:    y = ~(a | b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    logic [1:0] btn_s;
    logic [1:0] p_s;
    assign btn_s = {bus.btn2, bus.btn1};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic            sync0_r;
        logic            sync1_r;
        logic            db_r;
        logic [DB_W-1:0] cnt_r;

        // Synchronize the raw button and let the debounced level follow after a stable run.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync0_r <= 1'b1;
                sync1_r <= 1'b1;
                db_r    <= 1'b1;
                cnt_r   <= '0;
            end else begin
                sync0_r <= btn_s[i];
                sync1_r <= sync0_r;
                if (sync1_r != db_r) begin
                    if (cnt_r == DB_MAX) begin
                        db_r  <= sync1_r;
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end else begin
                    cnt_r <= '0;
                end
            end
        end

        assign p_s[i] = ~db_r;
    end

    top_state_e   state_r, state_nxt;
    chord_state_e chord_r, chord_nxt;
    logic [2:0]      mode_r, mode_nxt;
    logic [1:0]      step_r, step_nxt;
    logic [ST_W-1:0] dwell_r, dwell_nxt;
    logic [LG_W-1:0] hold_r, hold_nxt;
    logic [1:0]      p_prev_r;
    logic [5:0]      led_r, led_nxt;
    logic            start_sweep_s, press_edge_s, a_s, b_s, y_s;

    // State registers for both FSMs, their counters and the LED bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= LIVE;
            chord_r  <= C_IDLE;
            mode_r   <= 3'd0;
            step_r   <= 2'd0;
            dwell_r  <= '0;
            hold_r   <= '0;
            p_prev_r <= 2'b00;
            led_r    <= 6'b111111;
        end else begin
            state_r  <= state_nxt;
            chord_r  <= chord_nxt;
            mode_r   <= mode_nxt;
            step_r   <= step_nxt;
            dwell_r  <= dwell_nxt;
            hold_r   <= hold_nxt;
            p_prev_r <= p_s;
            led_r    <= led_nxt;
        end
    end

    // Chord and sweep sequencing, gate evaluation and LED image.
    always_comb begin
        state_nxt     = state_r;
        chord_nxt     = chord_r;
        mode_nxt      = mode_r;
        step_nxt      = step_r;
        dwell_nxt     = dwell_r;
        hold_nxt      = hold_r;
        start_sweep_s = 1'b0;
        press_edge_s  = |(p_s & ~p_prev_r);

        // Mode change and sweep start are muted while a sweep runs; the press edge aborts it instead.
        case (chord_r)
            C_IDLE: begin
                if (p_s == 2'b11) begin
                    chord_nxt = C_HOLD;
                    hold_nxt  = '0;
                end else begin
                    chord_nxt = C_IDLE;
                end
            end
            C_HOLD: begin
                if (p_s != 2'b11) begin
                    if (state_r == LIVE) begin
                        mode_nxt = (mode_r == 3'd5) ? 3'd0 : mode_r + 3'd1;
                    end else begin
                        mode_nxt = mode_r;
                    end
                    chord_nxt = C_WAIT_REL;
                end else if (hold_r == LG_MAX) begin
                    start_sweep_s = (state_r == LIVE);
                    chord_nxt     = C_WAIT_REL;
                end else begin
                    hold_nxt = hold_r + 1'b1;
                end
            end
            C_WAIT_REL: begin
                if (p_s == 2'b00) begin
                    chord_nxt = C_IDLE;
                end else begin
                    chord_nxt = C_WAIT_REL;
                end
            end
            default: chord_nxt = C_IDLE;
        endcase

        case (state_r)
            LIVE: begin
                if (start_sweep_s) begin
                    state_nxt = SWEEP;
                    step_nxt  = 2'd0;
                    dwell_nxt = '0;
                end else begin
                    state_nxt = LIVE;
                end
            end
            SWEEP: begin
                if (press_edge_s) begin
                    state_nxt = LIVE;
                end else if (dwell_r == ST_MAX) begin
                    dwell_nxt = '0;
                    if (step_r == 2'd3) begin
                        state_nxt = LIVE;
                    end else begin
                        step_nxt = step_r + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell_r + 1'b1;
                end
            end
            default: state_nxt = LIVE;
        endcase

        if (state_r == SWEEP) begin
            a_s = step_r[1];
            b_s = step_r[0];
        end else begin
            a_s = p_s[0];
            b_s = p_s[1];
        end
        y_s = gate_fn(mode_r, a_s, b_s);

        led_nxt = {~(chord_nxt == C_HOLD), ~(state_nxt == SWEEP), ~mode_nxt, ~y_s};
    end

    assign bus.led = led_r;
endmodule

// File: tb/tb_gate_demo_ctrl.sv
// Randomized and directed bench for gate_demo_ctrl against a truth-table based reference model.
module tb_gate_demo_ctrl;
    localparam int DB = 4;
    localparam int LG = 20;
    localparam int ST = 8;
    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_WAIT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gate_demo_if bus();

    gate_demo_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES(LG),
        .STEP_CYCLES(ST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Truth tables indexed by {a,b}: AND, OR, XOR, XNOR, NAND, NOR.
    bit [3:0] gate_tt [6] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0001};

    bit [1:0] m_d1, m_d2, m_rel, m_pp;
    int       m_run [2];
    bit       m_sweep;
    int       m_sweep_t;
    int       m_chord;
    int       m_hold_t;
    bit [2:0] m_mode;
    bit [5:0] m_led;
    bit [5:0] saved_led;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = 2'b11; m_d2 = 2'b11; m_rel = 2'b11; m_pp = 2'b00;
        m_run[0] = 0; m_run[1] = 0;
        m_sweep = 1'b0; m_sweep_t = 0;
        m_chord = M_IDLE; m_hold_t = 0;
        m_mode = 3'd0;
        m_led = 6'h3F;
    endtask

    task automatic model_edge(input bit r1, input bit r2);
        bit [1:0] p, rise;
        bit a, b, y, start;
        int step;
        p = ~m_rel;
        rise = p & ~m_pp;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (m_d2[i] != m_rel[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_rel[i] = m_d2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = {r2, r1};
        m_pp = p;
        if (m_sweep) begin
            step = m_sweep_t / ST;
            a = (step >= 2);
            b = (step % 2 == 1);
        end else begin
            a = p[0];
            b = p[1];
        end
        y = gate_tt[m_mode][{a, b}];
        case (m_chord)
            M_IDLE: if (p == 2'b11) begin m_chord = M_HOLD; m_hold_t = 0; end
            M_HOLD: begin
                if (p != 2'b11) begin
                    if (!m_sweep) m_mode = 3'((m_mode + 1) % 6);
                    m_chord = M_WAIT;
                end else if (m_hold_t == LG - 1) begin
                    start = !m_sweep;
                    m_chord = M_WAIT;
                end else begin
                    m_hold_t++;
                end
            end
            default: if (p == 2'b00) m_chord = M_IDLE;
        endcase
        if (m_sweep) begin
            if (rise != 2'b00 || m_sweep_t == 4 * ST - 1) m_sweep = 1'b0;
            else m_sweep_t++;
        end else if (start) begin
            m_sweep = 1'b1;
            m_sweep_t = 0;
        end
        m_led = {m_chord != M_HOLD, !m_sweep, ~m_mode, ~y};
    endtask

    task automatic cyc(input bit b1, input bit b2);
        bus.btn1 = b1;
        bus.btn2 = b2;
        @(posedge clk);
        model_edge(b1, b2);
        #1;
        check_eq("led", bus.led, m_led);
    endtask

    task automatic run(input bit b1, input bit b2, input int n);
        repeat (n) cyc(b1, b2);
    endtask

    initial begin
        bit [1:0] pat;
        int n;
        rst_n = 1'b0;
        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        model_reset();
        #12;
        check_eq("reset_led", bus.led, 6'h3F);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b1);
        check_eq("first_edge", bus.led, 6'h3F);

        // Short chord -> mode 1 (OR), then btn1 alone lights the result.
        run(1'b0, 1'b0, 6);
        run(1'b1, 1'b1, 12);
        check_eq("mode1", bus.led[3:1], 3'b110);
        run(1'b0, 1'b1, 10);
        check_eq("or_led0", bus.led[0], 1'b0);
        run(1'b1, 1'b1, 12);

        // Bounce shorter than the debounce window.
        saved_led = m_led;
        repeat (5) begin
            run(1'b0, 1'b1, 2);
            run(1'b1, 1'b1, 2);
        end
        check_eq("bounce", bus.led, saved_led);
        run(1'b1, 1'b1, 4);

        repeat (5) begin
            run(1'b0, 1'b0, 6);
            run(1'b1, 1'b1, 12);
        end
        check_eq("wrap", bus.led[3:1], 3'b111);
        repeat (3) begin
            run(1'b0, 1'b0, 6);
            run(1'b1, 1'b1, 12);
        end
        check_eq("mode3", bus.led[3:1], 3'b100);

        // Long hold starts a full sweep.
        run(1'b0, 1'b0, 32);
        check_eq("sweep_on", bus.led[4], 1'b0);
        run(1'b1, 1'b1, 40);
        check_eq("sweep_done", bus.led[4], 1'b1);

        // Second sweep aborted by a btn2 press.
        run(1'b0, 1'b0, 32);
        run(1'b1, 1'b1, 8);
        check_eq("sweep_on2", bus.led[4], 1'b0);
        run(1'b1, 1'b0, 10);
        check_eq("abort", bus.led[4], 1'b1);
        run(1'b1, 1'b1, 12);

        // Reset during a chord hold.
        run(1'b0, 1'b0, 12);
        check_eq("hold_lit", bus.led[5], 1'b0);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", bus.led, 6'h3F);
        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        model_reset();
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(1'b1, 1'b1, 4);

        repeat (80) begin
            pat = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 30);
            run(pat[0], pat[1], n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
